// File: rtl/pipe_ctrl_chain.sv
// rtl/pipe_ctrl_chain.sv - control-path pipeline with load-use stall and forwarding selects
//
// Carries the decoded control bundle from ID through STAGES back-end stages
// (stage 0 = EX, stage STAGES-1 = WB), tracking valid/rd per stage.
// Optional feature macro: PIPE_CTRL_PERF_EN (stall/bubble perf counters).
//
// Ports:
//   Clk, Reset              clock, synchronous active-high reset
//   id_*                    decoded instruction from ID
//   hold, flush             global freeze, branch kill of incoming instruction
//   stg_valid/ctrl/rf_enable/load/rd   per-stage state, stage s in slice s
//   stall                   load-use hazard; upstream must not advance
//   fwd_rn, fwd_rm          one-hot forward source stage, zero = register file
//   stall_cnt, bubble_cnt   saturating perf counters (zero when feature off)
module pipe_ctrl_chain #(
  parameter int CTRL_W = 12,
  parameter int STAGES = 3,
  parameter int RA_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     id_valid,
  input  logic [CTRL_W-1:0]        id_ctrl,
  input  logic                     id_rf_enable,
  input  logic                     id_load,
  input  logic [RA_W-1:0]          id_rd,
  input  logic [RA_W-1:0]          id_rn,
  input  logic [RA_W-1:0]          id_rm,
  input  logic                     id_use_rn,
  input  logic                     id_use_rm,
  input  logic                     hold,
  input  logic                     flush,
  output logic [STAGES-1:0]        stg_valid,
  output logic [STAGES*CTRL_W-1:0] stg_ctrl,
  output logic [STAGES-1:0]        stg_rf_enable,
  output logic [STAGES-1:0]        stg_load,
  output logic [STAGES*RA_W-1:0]   stg_rd,
  output logic                     stall,
  output logic [STAGES-1:0]        fwd_rn,
  output logic [STAGES-1:0]        fwd_rm,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
);

  // Register 15 is the PC: it never stalls and is never forwarded.
  localparam logic [RA_W-1:0] PC_REG = RA_W'(15);

  logic [RA_W-1:0]   rd0;
  logic              hazard;
  logic              bubble;
  logic [CTRL_W-1:0] in_ctrl;
  logic [RA_W-1:0]   in_rd;
  logic              in_rf_enable;
  logic              in_load;

  assign rd0 = stg_rd[RA_W-1:0];

  assign hazard = stg_valid[0] & stg_load[0] & stg_rf_enable[0] & (rd0 != PC_REG) &
                  ((id_use_rn & (id_rn == rd0)) | (id_use_rm & (id_rm == rd0)));

  // Flush beats the hazard (the dependent instruction is being killed anyway);
  // hold masks it so it re-evaluates once the freeze lifts.
  assign stall  = ~hold & id_valid & ~flush & hazard;
  assign bubble = ~id_valid | flush | stall;

  assign in_ctrl      = bubble ? '0 : id_ctrl;
  assign in_rd        = bubble ? '0 : id_rd;
  assign in_rf_enable = ~bubble & id_rf_enable;
  assign in_load      = ~bubble & id_load;

  // Scan from the oldest stage down so the youngest (lowest-index) producer
  // overwrites the select last and wins.
  always_comb begin : fwd_scan
    logic [RA_W-1:0] rd_s;
    logic            wr_s;
    fwd_rn = '0;
    fwd_rm = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      rd_s = stg_rd[s*RA_W +: RA_W];
      // A stage-0 load has no data yet; that case is the stall path.
      wr_s = stg_valid[s] & stg_rf_enable[s] & ~((s == 0) & stg_load[s]) & (rd_s != PC_REG);
      if (wr_s && id_use_rn && (id_rn == rd_s)) begin
        fwd_rn    = '0;
        fwd_rn[s] = 1'b1;
      end
      if (wr_s && id_use_rm && (id_rm == rd_s)) begin
        fwd_rm    = '0;
        fwd_rm[s] = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stg_valid     <= '0;
      stg_ctrl      <= '0;
      stg_rf_enable <= '0;
      stg_load      <= '0;
      stg_rd        <= '0;
    end else if (!hold) begin
      stg_valid     <= {stg_valid[STAGES-2:0], ~bubble};
      stg_ctrl      <= {stg_ctrl[(STAGES-1)*CTRL_W-1:0], in_ctrl};
      stg_rf_enable <= {stg_rf_enable[STAGES-2:0], in_rf_enable};
      stg_load      <= {stg_load[STAGES-2:0], in_load};
      stg_rd        <= {stg_rd[(STAGES-1)*RA_W-1:0], in_rd};
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (!hold) begin
      if (stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (bubble && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// tb/tb_pipe_ctrl_chain.sv - self-checking bench for pipe_ctrl_chain
module tb_pipe_ctrl_chain;

  localparam int CTRL_W = 12;
  localparam int STAGES = 3;
  localparam int RA_W   = 4;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                     Clk;
  logic                     Reset;
  logic                     id_valid;
  logic [CTRL_W-1:0]        id_ctrl;
  logic                     id_rf_enable;
  logic                     id_load;
  logic [RA_W-1:0]          id_rd;
  logic [RA_W-1:0]          id_rn;
  logic [RA_W-1:0]          id_rm;
  logic                     id_use_rn;
  logic                     id_use_rm;
  logic                     hold;
  logic                     flush;
  logic [STAGES-1:0]        stg_valid;
  logic [STAGES*CTRL_W-1:0] stg_ctrl;
  logic [STAGES-1:0]        stg_rf_enable;
  logic [STAGES-1:0]        stg_load;
  logic [STAGES*RA_W-1:0]   stg_rd;
  logic                     stall;
  logic [STAGES-1:0]        fwd_rn;
  logic [STAGES-1:0]        fwd_rm;
  logic [CNT_W-1:0]         stall_cnt;
  logic [CNT_W-1:0]         bubble_cnt;

  pipe_ctrl_chain #(
    .CTRL_W(CTRL_W), .STAGES(STAGES), .RA_W(RA_W), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .id_valid(id_valid), .id_ctrl(id_ctrl), .id_rf_enable(id_rf_enable),
    .id_load(id_load), .id_rd(id_rd), .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .hold(hold), .flush(flush),
    .stg_valid(stg_valid), .stg_ctrl(stg_ctrl), .stg_rf_enable(stg_rf_enable),
    .stg_load(stg_load), .stg_rd(stg_rd), .stall(stall),
    .fwd_rn(fwd_rn), .fwd_rm(fwd_rm),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit        v;
    bit [11:0] ctrl;
    bit        rf;
    bit        ld;
    bit [3:0]  rd;
    bit [3:0]  rn;
    bit [3:0]  rm;
    bit        urn;
    bit        urm;
    bit        hold;
    bit        flush;
    bit        rst;
  } in_t;

  typedef struct {
    in_t       i;
    bit        e_stall;
    bit [2:0]  e_frn;
    bit [2:0]  e_frm;
    bit [2:0]  e_valid;
    bit [11:0] e_ctrl2;
  } vec_t;

  typedef struct {
    bit        v;
    bit [11:0] ctrl;
    bit        rf;
    bit        ld;
    bit [3:0]  rd;
  } instr_t;

  int checks = 0;
  int errors = 0;

  // Reference model: a list of in-flight instructions, youngest first.
  instr_t m[STAGES];
  int     m_scnt;
  int     m_bcnt;
  vec_t   tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic in_t ins(bit v, bit [11:0] ctrl, bit rf, bit ld, bit [3:0] rd,
                              bit [3:0] rn, bit [3:0] rm, bit urn, bit urm,
                              bit hd, bit fl, bit rs);
    in_t x;
    x.v = v; x.ctrl = ctrl; x.rf = rf; x.ld = ld; x.rd = rd;
    x.rn = rn; x.rm = rm; x.urn = urn; x.urm = urm;
    x.hold = hd; x.flush = fl; x.rst = rs;
    return x;
  endfunction

  task automatic add(input in_t x, input bit st, input bit [2:0] frn, input bit [2:0] frm,
                     input bit [2:0] vld, input bit [11:0] c2);
    vec_t r;
    r.i = x; r.e_stall = st; r.e_frn = frn; r.e_frm = frm; r.e_valid = vld; r.e_ctrl2 = c2;
    tbl.push_back(r);
  endtask

  // The incoming instruction depends on a load that is still in EX.
  function automatic bit m_stall(in_t x);
    bit dep;
    dep = (x.urn && x.rn == m[0].rd) || (x.urm && x.rm == m[0].rd);
    return !x.hold && x.v && !x.flush && m[0].v && m[0].ld && m[0].rf &&
           m[0].rd != 4'd15 && dep;
  endfunction

  // Youngest stage holding a usable result for this source.
  function automatic bit [STAGES-1:0] m_fwd(bit [3:0] src, bit used);
    bit [STAGES-1:0] r;
    r = '0;
    if (!used || src == 4'd15) return r;
    for (int s = 0; s < STAGES; s++) begin
      if (m[s].v && m[s].rf && m[s].rd == src && !(s == 0 && m[s].ld)) begin
        r[s] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_edge(input in_t x);
    bit     st;
    instr_t n;
    st = m_stall(x);
    if (x.rst) begin
      for (int s = 0; s < STAGES; s++) m[s] = '{default: 0};
      m_scnt = 0;
      m_bcnt = 0;
    end else if (!x.hold) begin
      n = '{default: 0};
      if (x.v && !x.flush && !st) begin
        n.v = 1'b1; n.ctrl = x.ctrl; n.rf = x.rf; n.ld = x.ld; n.rd = x.rd;
      end else if (m_bcnt < CMAX) begin
        m_bcnt++;
      end
      if (st && m_scnt < CMAX) m_scnt++;
      for (int s = STAGES - 1; s > 0; s--) m[s] = m[s-1];
      m[0] = n;
    end
  endtask

  task automatic check_model(input in_t x);
    logic [STAGES-1:0]        ev, erf, eld;
    logic [STAGES*CTRL_W-1:0] ec;
    logic [STAGES*RA_W-1:0]   er;
    for (int s = 0; s < STAGES; s++) begin
      ev[s] = m[s].v; erf[s] = m[s].rf; eld[s] = m[s].ld;
      ec[s*CTRL_W +: CTRL_W] = m[s].ctrl;
      er[s*RA_W +: RA_W] = m[s].rd;
    end
    chk("m_valid", 64'(stg_valid), 64'(ev));
    chk("m_ctrl", 64'(stg_ctrl), 64'(ec));
    chk("m_rf_enable", 64'(stg_rf_enable), 64'(erf));
    chk("m_load", 64'(stg_load), 64'(eld));
    chk("m_rd", 64'(stg_rd), 64'(er));
    chk("m_stall", 64'(stall), 64'(m_stall(x)));
    chk("m_fwd_rn", 64'(fwd_rn), 64'(m_fwd(x.rn, x.urn)));
    chk("m_fwd_rm", 64'(fwd_rm), 64'(m_fwd(x.rm, x.urm)));
    chk("m_stall_cnt", 64'(stall_cnt), PERF ? 64'(m_scnt) : 64'd0);
    chk("m_bubble_cnt", 64'(bubble_cnt), PERF ? 64'(m_bcnt) : 64'd0);
  endtask

  task automatic drive(input in_t x);
    @(negedge Clk);
    id_valid = x.v; id_ctrl = x.ctrl; id_rf_enable = x.rf; id_load = x.ld;
    id_rd = x.rd; id_rn = x.rn; id_rm = x.rm; id_use_rn = x.urn; id_use_rm = x.urm;
    hold = x.hold; flush = x.flush; Reset = x.rst;
    #1;
  endtask

  task automatic tick(input in_t x);
    @(posedge Clk);
    model_edge(x);
  endtask

  task automatic cycle(input in_t x, input bit use_model);
    drive(x);
    if (use_model) check_model(x);
    tick(x);
  endtask

  in_t idle, rst_in, x;
  int  r;

  initial begin
    for (int s = 0; s < STAGES; s++) m[s] = '{default: 0};
    m_scnt = 0;
    m_bcnt = 0;
    idle   = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_in = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Pure advance
    add(ins(1, 12'h001, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0, 3'b000, 3'b000, 3'b000, 12'h000);
    add(ins(1, 12'h002, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0), 0, 3'b000, 3'b000, 3'b001, 12'h000);
    add(ins(1, 12'h003, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0), 0, 3'b000, 3'b000, 3'b011, 12'h000);
    add(ins(1, 12'h004, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0), 0, 3'b000, 3'b000, 3'b111, 12'h001);
    add(idle,                                          0, 3'b000, 3'b000, 3'b111, 12'h002);
    add(idle,                                          0, 3'b000, 3'b000, 3'b110, 12'h003);
    add(idle,                                          0, 3'b000, 3'b000, 3'b100, 12'h004);
    // Load-use: LDR R3 then ADD reading R3, presented twice
    add(ins(1, 12'h010, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0), 0, 3'b000, 3'b000, 3'b000, 12'h000);
    add(ins(1, 12'h020, 1, 0, 4, 3, 0, 1, 0, 0, 0, 0), 1, 3'b000, 3'b000, 3'b001, 12'h000);
    add(ins(1, 12'h020, 1, 0, 4, 3, 0, 1, 0, 0, 0, 0), 0, 3'b010, 3'b000, 3'b010, 12'h000);
    // Forward priority: three writers of R5
    add(ins(1, 12'h031, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0), 0, 3'b000, 3'b000, 3'b101, 12'h010);
    add(ins(1, 12'h032, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0), 0, 3'b000, 3'b000, 3'b011, 12'h000);
    add(ins(1, 12'h033, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0), 0, 3'b000, 3'b000, 3'b111, 12'h020);
    add(ins(1, 12'h040, 0, 0, 0, 0, 5, 0, 1, 0, 1, 0), 0, 3'b000, 3'b001, 3'b111, 12'h031);
    add(ins(1, 12'h040, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0), 0, 3'b000, 3'b010, 3'b110, 12'h032);
    // R15 never stalls and never forwards
    add(ins(1, 12'h050, 1, 1, 15, 0, 0, 0, 0, 0, 0, 0), 0, 3'b000, 3'b000, 3'b101, 12'h033);
    add(ins(1, 12'h060, 1, 0, 6, 15, 15, 1, 1, 0, 0, 0), 0, 3'b000, 3'b000, 3'b011, 12'h000);
    add(ins(1, 12'h061, 1, 0, 6, 15, 15, 1, 1, 0, 0, 0), 0, 3'b000, 3'b000, 3'b111, 12'h040);
    // Hazard plus flush: flush wins
    add(ins(1, 12'h070, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0), 0, 3'b000, 3'b000, 3'b111, 12'h050);
    add(ins(1, 12'h080, 1, 0, 8, 7, 0, 1, 0, 0, 1, 0), 0, 3'b000, 3'b000, 3'b111, 12'h060);
    add(idle,                                          0, 3'b000, 3'b000, 3'b110, 12'h061);
    // Hold freezes the pipe
    add(ins(1, 12'h090, 1, 1, 9, 0, 0, 0, 0, 1, 0, 0), 0, 3'b000, 3'b000, 3'b100, 12'h070);
    add(ins(1, 12'h090, 1, 1, 9, 0, 0, 0, 0, 1, 0, 0), 0, 3'b000, 3'b000, 3'b100, 12'h070);
    add(ins(1, 12'h090, 1, 1, 9, 0, 0, 0, 0, 1, 0, 0), 0, 3'b000, 3'b000, 3'b100, 12'h070);
    add(ins(1, 12'h090, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0), 0, 3'b000, 3'b000, 3'b100, 12'h070);
    // Hazard masked by hold, then visible once hold drops
    add(ins(1, 12'h0A0, 1, 0, 10, 9, 0, 1, 0, 1, 0, 0), 0, 3'b000, 3'b000, 3'b001, 12'h000);
    add(ins(1, 12'h0A0, 1, 0, 10, 9, 0, 1, 0, 0, 0, 0), 1, 3'b000, 3'b000, 3'b001, 12'h000);
    // Reset overrides hold
    add(ins(1, 12'h0A0, 1, 0, 10, 9, 0, 1, 0, 1, 0, 1), 0, 3'b010, 3'b000, 3'b010, 12'h000);
    add(idle,                                          0, 3'b000, 3'b000, 3'b000, 12'h000);

    Reset = 1'b1;
    cycle(rst_in, 0);
    cycle(rst_in, 0);

    // Reset state against constants
    drive(idle);
    chk("rst_valid", 64'(stg_valid), 64'd0);
    chk("rst_ctrl", 64'(stg_ctrl), 64'd0);
    chk("rst_rf_load", 64'({stg_rf_enable, stg_load}), 64'd0);
    chk("rst_rd", 64'(stg_rd), 64'd0);
    chk("rst_stall_fwd", 64'({stall, fwd_rn, fwd_rm}), 64'd0);
    chk("rst_counters", 64'({stall_cnt, bubble_cnt}), 64'd0);
    tick(idle);

    cycle(rst_in, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].i);
      chk($sformatf("tbl%0d_stall", i), 64'(stall), 64'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_fwd_rn", i), 64'(fwd_rn), 64'(tbl[i].e_frn));
      chk($sformatf("tbl%0d_fwd_rm", i), 64'(fwd_rm), 64'(tbl[i].e_frm));
      chk($sformatf("tbl%0d_valid", i), 64'(stg_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_ctrl2", i), 64'(stg_ctrl[2*CTRL_W +: CTRL_W]), 64'(tbl[i].e_ctrl2));
      check_model(tbl[i].i);
      tick(tbl[i].i);
    end

    // Load-use counter effect: one stall, bubbles from the stall plus idles
    cycle(rst_in, 0);
    cycle(ins(1, 12'h010, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0), 1);
    cycle(ins(1, 12'h020, 1, 0, 4, 0, 3, 0, 1, 0, 0, 0), 1);
    drive(ins(1, 12'h020, 1, 0, 4, 0, 3, 0, 1, 0, 0, 0));
    chk("lu_stall_cnt", 64'(stall_cnt), PERF ? 64'd1 : 64'd0);
    chk("lu_bubble_cnt", 64'(bubble_cnt), PERF ? 64'd1 : 64'd0);
    chk("lu_fwd_rm", 64'(fwd_rm), 64'b010);
    tick(ins(1, 12'h020, 1, 0, 4, 0, 3, 0, 1, 0, 0, 0));

    // Saturation: 20 bubbles after reset
    cycle(rst_in, 0);
    for (int k = 0; k < 20; k++) cycle(idle, 1);
    drive(idle);
    chk("sat_bubble_cnt", 64'(bubble_cnt), PERF ? 64'(CMAX) : 64'd0);
    chk("sat_stall_cnt", 64'(stall_cnt), 64'd0);
    tick(idle);

    // Randomized run against the model
    for (int k = 0; k < 600; k++) begin
      x.v     = ($urandom_range(0, 9) < 8);
      x.ctrl  = 12'($urandom);
      x.rf    = ($urandom_range(0, 3) != 0);
      x.ld    = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 4); x.rd = (r == 4) ? 4'd15 : 4'(r);
      r = $urandom_range(0, 4); x.rn = (r == 4) ? 4'd15 : 4'(r);
      r = $urandom_range(0, 4); x.rm = (r == 4) ? 4'd15 : 4'(r);
      x.urn   = $urandom_range(0, 1);
      x.urm   = $urandom_range(0, 1);
      x.hold  = ($urandom_range(0, 9) == 0);
      x.flush = ($urandom_range(0, 9) == 0);
      x.rst   = ($urandom_range(0, 63) == 0);
      cycle(x, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
